fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_pkg.sv | 31 +++
 rtl/fifo_rd_skid.sv | 76 +++++++
 rtl/fifo_rd_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read controller: FSM state encoding,
// output buffer depth and the read-credit check used to pace fifo_rd_en.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef logic [SKID_CNT_W:0] credit_t;

    // A read may be issued only if the word it returns still has a buffer slot,
    // counting words already buffered and the one in flight, net of a same-cycle pop.
    function automatic logic has_credit(
        input logic [SKID_CNT_W-1:0] occupancy,
        input logic                  inflight,
        input logic                  pop
    );
        credit_t used;
        credit_t limit;
        used  = credit_t'(occupancy) + credit_t'(inflight);
        limit = credit_t'(SKID_DEPTH) + credit_t'(pop);
        return used < limit;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small output buffer between the FIFO read port and the stream interface.
// Entry 0 is always the head; pops shift the remaining entries toward it.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_W-1:0]     data,
    output logic [SKID_CNT_W-1:0] count
);

    logic [SKID_CNT_W-1:0] count_reg;
    logic [SKID_CNT_W-1:0] count_next;
    logic [SKID_CNT_W-1:0] wr_idx;
    logic                  pop_ok;
    logic [DATA_W-1:0]     slot_val [SKID_DEPTH];

    assign pop_ok = pop && (count_reg != '0);

    // The incoming word lands just behind whatever survives this cycle's pop.
    assign wr_idx = count_reg - SKID_CNT_W'(pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({push, pop_ok})
            2'b10:   count_next = count_reg + SKID_CNT_W'(1);
            2'b01:   count_next = count_reg - SKID_CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg;
            logic [DATA_W-1:0] shift_in;

            if (gi < SKID_DEPTH - 1) begin : g_mid
                assign shift_in = slot_val[gi+1];
            end else begin : g_last
                assign shift_in = slot_reg;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (push && (wr_idx == SKID_CNT_W'(gi))) begin
                    slot_reg <= push_data;
                end else if (pop_ok) begin
                    slot_reg <= shift_in;
                end
            end

            assign slot_val[gi] = slot_reg;
        end
    endgenerate

    assign valid = (count_reg != '0);
    assign data  = slot_val[0];
    assign count = count_reg;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst reader: pulls burst_len words from a FIFO and presents them as a
// valid/ready stream. Optional m_parity output enabled by FIFO_RD_PARITY_EN.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done,
`ifdef FIFO_RD_PARITY_EN
    output logic              m_parity,
`endif
    output logic [LEN_W-1:0]  rd_count
);

    state_e                state_reg;
    state_e                state_next;
    logic [LEN_W-1:0]      len_reg;
    logic [LEN_W-1:0]      issued_reg;
    logic [LEN_W-1:0]      rd_count_reg;
    logic                  inflight_reg;
    logic [SKID_CNT_W-1:0] occupancy;
    logic                  pop;
    logic                  last_pop;
    logic                  start_ok;
    logic                  rd_en;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (fifo_dout),
        .pop       (pop),
        .valid     (m_valid),
        .data      (m_data),
        .count     (occupancy)
    );

    assign pop      = m_valid && m_ready;
    assign start_ok = (state_reg == IDLE) && start;
    assign last_pop = pop && (rd_count_reg == (len_reg - LEN_W'(1)));

    // Gated by reset so no word is popped from the FIFO while the buffer is being flushed.
    always_comb begin
        rd_en = 1'b0;
        if (!reset && (state_reg == READ) && !fifo_empty && (issued_reg != len_reg)) begin
            rd_en = has_credit(occupancy, inflight_reg, pop);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (burst_len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (issued_reg == len_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            issued_reg   <= '0;
            rd_count_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd_en;
            if (start_ok) begin
                len_reg      <= burst_len;
                issued_reg   <= '0;
                rd_count_reg <= '0;
            end else begin
                if (rd_en) begin
                    issued_reg <= issued_reg + LEN_W'(1);
                end
                if (pop) begin
                    rd_count_reg <= rd_count_reg + LEN_W'(1);
                end
            end
        end
    end

    always_comb begin
        fifo_rd_en = rd_en;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        rd_count   = rd_count_reg;
    end

`ifdef FIFO_RD_PARITY_EN
    assign m_parity = ^m_data;
`endif

endmodule
